// File: rtl/mips_trace_buffer_if.sv
// Trace buffer control, sample and read-port bundle.
// master drives arm/trigger/sample/rd_ready; slave returns state and read data.
interface mips_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             arm;
  logic [1:0]       trig_mode;
  logic [XLEN-1:0]  trig_value;
  logic             force_trig;
  logic             sample_en;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic [XLEN-1:0]  alu_result;
  logic             zero;
  logic [1:0]       state;
  logic             triggered;
  logic [CNT_W-1:0] count;
  logic             rd_valid;
  logic             rd_ready;
  logic [XLEN-1:0]  rd_pc;
  logic [31:0]      rd_instr;
  logic [XLEN-1:0]  rd_alu;
  logic             rd_zero;
  logic [CYC_W-1:0] rd_stamp;
  logic             rd_last;

  modport master (
    output arm, trig_mode, trig_value, force_trig,
    output sample_en, pc, instr, alu_result, zero,
    output rd_ready,
    input  state, triggered, count, rd_valid,
    input  rd_pc, rd_instr, rd_alu, rd_zero, rd_stamp, rd_last
  );

  modport slave (
    input  arm, trig_mode, trig_value, force_trig,
    input  sample_en, pc, instr, alu_result, zero,
    input  rd_ready,
    output state, triggered, count, rd_valid,
    output rd_pc, rd_instr, rd_alu, rd_zero, rd_stamp, rd_last
  );
endinterface

// File: rtl/mips_trace_buffer.sv
// Execution-trace capture: circular buffer with pre/post-trigger windows.
// Ports: clk, reset (sync, active-low), bus (slave modport of the trace if).
module mips_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 8,
  parameter int CYC_W      = 16
) (
  input logic              clk,
  input logic              reset,
  mips_trace_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PR_W  = $clog2(POST_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PR_W-1:0]  post_rem_q, post_rem_d;
  logic [CYC_W-1:0] stamp_q, stamp_d;

  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [XLEN-1:0]  alu_mem_q   [DEPTH];
  logic             zero_mem_q  [DEPTH];
  logic [CYC_W-1:0] stamp_mem_q [DEPTH];

  logic             capture;
  logic             hit;
  logic             mode_match;
  logic             rd_valid;
  logic             xfer;
  logic [PTR_W-1:0] rd_idx;

  always_comb begin
    mode_match = 1'b0;
    unique case (bus.trig_mode)
      2'b00: mode_match = 1'b0;
      2'b01: mode_match = (bus.pc == bus.trig_value);
      2'b10: mode_match = (bus.instr == bus.trig_value[31:0]);
      2'b11: mode_match = bus.zero;
    endcase
  end

  always_comb begin
    capture  = (state_q == S_ARMED || state_q == S_POST)
             && bus.sample_en && !bus.arm;
    hit      = (state_q == S_ARMED)
             && (bus.force_trig || (bus.sample_en && mode_match));
    rd_valid = (state_q == S_DONE) && (count_q != '0);
    xfer     = rd_valid && bus.rd_ready;
    // count == DEPTH wraps to 0 in the low bits: oldest is at wr_ptr
    rd_idx   = wr_ptr_q - count_q[PTR_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    post_rem_d = post_rem_q;
    stamp_d    = stamp_q + 1'b1;

    if (capture) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != CNT_W'(DEPTH))
        count_d = count_q + 1'b1;
    end

    if (bus.arm) begin
      state_d    = S_ARMED;
      count_d    = '0;
      wr_ptr_d   = '0;
      post_rem_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (hit) begin
            state_d = S_POST;
            if (bus.sample_en) begin
              post_rem_d = PR_W'(POST_DEPTH - 1);
              if (PR_W'(POST_DEPTH - 1) == '0)
                state_d = S_DONE;
            end else begin
              post_rem_d = PR_W'(POST_DEPTH);
            end
          end
        end
        S_POST: begin
          if (bus.sample_en) begin
            post_rem_d = post_rem_q - 1'b1;
            if (post_rem_q == PR_W'(1))
              state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (count_q == '0) begin
            state_d = S_IDLE;
          end else if (xfer) begin
            count_d = count_q - 1'b1;
            if (count_q == CNT_W'(1))
              state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      post_rem_q <= '0;
      stamp_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      post_rem_q <= post_rem_d;
      stamp_q    <= stamp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && capture) begin
      pc_mem_q[wr_ptr_q]    <= bus.pc;
      instr_mem_q[wr_ptr_q] <= bus.instr;
      alu_mem_q[wr_ptr_q]   <= bus.alu_result;
      zero_mem_q[wr_ptr_q]  <= bus.zero;
      stamp_mem_q[wr_ptr_q] <= stamp_q;
    end
  end

  assign bus.state     = state_q;
  assign bus.triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign bus.count     = count_q;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_pc     = rd_valid ? pc_mem_q[rd_idx]    : '0;
  assign bus.rd_instr  = rd_valid ? instr_mem_q[rd_idx] : '0;
  assign bus.rd_alu    = rd_valid ? alu_mem_q[rd_idx]   : '0;
  assign bus.rd_zero   = rd_valid ? zero_mem_q[rd_idx]  : 1'b0;
  assign bus.rd_stamp  = rd_valid ? stamp_mem_q[rd_idx] : '0;
  assign bus.rd_last   = rd_valid && (count_q == CNT_W'(1));
endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
- Synthesizable, parametrised execution-trace capture unit for the MIPS core; it replaces the print-only simulation monitor.
- Samples PC, instruction, ALU result and the zero flag on qualified cycles into a circular buffer, with pre- and post-trigger windows.
- Triggers on PC match, instruction match, the zero flag or a manual force.
- Presents the captured window oldest-first over a valid/ready read port, for on-chip debug or bench checking.

Parameters:
- XLEN, 32: width of pc, alu_result and trig_value.
- DEPTH, 16: buffer entries; power of two, at least 4.
- POST_DEPTH, 8: samples kept from the trigger onward, including the trigger sample; range 1..DEPTH.
- CYC_W, 16: width of the cycle timestamp.

Ports:
- clk in 1: the single clock.
- reset in 1: synchronous, active-low reset. Sampled on the rising edge of clk; reset=0 resets the block.
- arm in 1: single-cycle pulse; clears the buffer and enters ARMED.
- trig_mode in 2: 00 manual only, 01 pc==trig_value, 10 instr==trig_value[31:0], 11 zero==1.
- trig_value in XLEN: match value.
- force_trig in 1: manual trigger, honoured in any mode.
- sample_en in 1: core sample is valid this cycle.
- pc in XLEN, instr in 32, alu_result in XLEN, zero in 1: observed core signals.
- state out 2: 00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- triggered out 1: high in POST and DONE.
- count out clog2(DEPTH+1): number of valid entries.
- rd_valid out 1, rd_ready in 1: read handshake.
- rd_pc out XLEN, rd_instr out 32, rd_alu out XLEN, rd_zero out 1, rd_stamp out CYC_W: the oldest entry.
- rd_last out 1: the current entry is the final one.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, count=0, wr_ptr=0, post_rem=0, stamp=0, triggered=0, rd_valid=0. rd_* data outputs are 0 while rd_valid=0.
- stamp: free-running CYC_W counter, incremented every non-reset cycle. Wraps modulo 2^CYC_W.
- Sample capture (ARMED or POST, sample_en=1):
  - Write {pc, instr, alu_result, zero, stamp} at wr_ptr, then advance wr_ptr mod DEPTH.
  - count increments and saturates at DEPTH; once full, the oldest entry is overwritten.
- hit (evaluated in ARMED only) = force_trig | (sample_en & mode_match). In mode 00, only force_trig can produce a hit.
- IDLE:
  - arm=1 -> ARMED; count and wr_ptr cleared.
  - All other inputs are ignored.
- ARMED, hit=1 -> POST, post_rem=POST_DEPTH:
  - If sample_en=1 that cycle, the sample is stored and post_rem=POST_DEPTH-1 instead.
  - If post_rem reaches 0 in that same cycle (POST_DEPTH=1), go directly to DONE.
  - force_trig with sample_en=0 stores nothing; post_rem=POST_DEPTH.
- POST:
  - Each stored sample decrements post_rem.
  - The cycle that stores the sample taking post_rem to 0 -> DONE, with that sample included.
  - Trigger inputs are ignored.
- DONE:
  - Capture is stopped; rd_valid = (count != 0).
  - Read index = (wr_ptr - count) mod DEPTH.
  - rd_* are driven combinationally from that index.
  - rd_last = (count==1).
  - On rd_valid & rd_ready, count decrements. When count goes 1->0 -> IDLE, with rd_valid low the next cycle.
  - rd_* stay stable while rd_valid=1 and rd_ready=0.
- DONE with count==0 on entry (force then no samples is impossible since POST_DEPTH>=1, but guarded): go to IDLE next cycle.
- arm in ARMED, POST or DONE: aborts; -> ARMED with count=0, wr_ptr=0, post_rem=0. arm takes priority over hit and over a read transfer in the same cycle.
- reset=0 in any state, including mid-readout with rd_ready high: the reset values above apply at that edge; no transfer completes.
- Latency: a sample is visible on the read port one cycle after DONE is entered. Throughput is one entry per cycle with rd_ready held high.
- Width rules:
  - Instruction match compares 32 bits: trig_value[31:0].
  - PC match compares the full XLEN.
  - Stamps are raw, with no wrap correction.

Test Plan (DEPTH=8, POST_DEPTH=4, XLEN=32, CYC_W=16):
1. Reset: hold reset=0 for 2 cycles with arm=1 and sample_en=1 -> state=00, count=0, rd_valid=0, triggered=0. Release, then idle 3 cycles -> state stays 00.
2. PC match trigger:
   - Stimulus: arm; mode=01; trig_value=0x20; sample_en=1; pc=0,4,8,... per cycle.
   - Trigger at pc=0x20; DONE after pc=0x2C is stored; count=8.
   - rd_ready=1 reads pc 0x10..0x2C in order, stamps consecutive, rd_last only on 0x2C; then state=00.
3. Partial pre-window:
   - Stimulus: arm; mode=00; samples pc=0,4; force_trig with sample_en=1 at pc=8; then pc=0xC,0x10,0x14.
   - DONE with count=6; readout order 0x0..0x14.
4. Back-pressure: in DONE, drive rd_ready alternating 1,0,1,0 -> each entry is delivered exactly once, rd_* are unchanged across stalled cycles, 8 transfers take 16 cycles.
5. Gaps and stamp wrap:
   - Stimulus: mode=11; stamp preloaded near 0xFFFE by running the clock; sample_en=1,0,1 pattern.
   - Unsampled cycles store nothing.
   - Trigger on the first zero=1 sampled cycle.
   - Stored stamps skip gaps and wrap 0xFFFF->0x0000.
6. Abort paths:
   - arm pulse in POST -> state=01, count=0.
   - reset=0 after 3 of 8 reads -> state=00, rd_valid=0 next cycle, no further data.
